// File: rtl/vga_sync_gen.sv
// Purpose : VGA raster timing generator (pixel strobe, h/v counters, syncs, display enable, line/frame pulses).
// Latency : counters, syncs, de and pulses are all registered together, one clk after the pix_en strobe is sampled.
// Backpress: none; free-running raster source, consumers sample on pix_en.
//
// Ports
//   clk          system clock (pixel rate is a clock-enable derived from it)
//   rst          asynchronous active-high reset
//   pix_en       one-clk strobe every CLK_DIV clks
//   h_cnt/v_cnt  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1 (line and frame both start at sync)
//   hsync/vsync  sync outputs, at HS_POL/VS_POL while inside the sync region
//   de           high inside the visible window
//   line_start   one-clk pulse on the edge where h_cnt becomes 0
//   frame_start  one-clk pulse on the edge where (h_cnt,v_cnt) becomes (0,0)
//   h_back_porch, h_visible, v_back_porch, v_visible
//                window constants for the downstream display stage (not reset)

module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_back_porch,
  output logic [10:0] h_visible,
  output logic [10:0] v_back_porch,
  output logic [10:0] v_visible
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
  localparam logic [10:0] H_VIS_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_VIS_END = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] V_VIS_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_VIS_END = 11'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [10:0] ONE11     = 11'd1;

  // Window constants, straight from parameters.
  assign h_back_porch = H_VIS_BEG;
  assign h_visible    = 11'(H_VISIBLE);
  assign v_back_porch = V_VIS_BEG;
  assign v_visible    = 11'(V_VISIBLE);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [10:0]      h_cnt_q, h_cnt_d;
  logic [10:0]      v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap, v_wrap;

  // Divider. pix_en is registered off the divider terminal count, so after
  // reset release the first strobe appears exactly CLK_DIV clks later and
  // with CLK_DIV=1 it is high on every clk after the first edge, while still
  // reading 0 during reset.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
    pix_en_d  = (div_cnt_q == DIV_LAST);
  end

  // Raster counters advance on the edge that samples pix_en high.
  // The >= compares keep the counters bounded even from an unexpected value.
  always_comb begin
    h_wrap  = (h_cnt_q >= H_LAST);
    v_wrap  = (v_cnt_q >= V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_q) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + ONE11;
      end else begin
        h_cnt_d = h_cnt_q + ONE11;
      end
    end
  end

  // Decodes are taken from the next counter values so that they land on the
  // same edge as the counters themselves: no skew between position and syncs.
  always_comb begin
    hsync_d       = (h_cnt_d < H_SYNC_L) ? HS_POL : ~HS_POL;
    vsync_d       = (v_cnt_d < V_SYNC_L) ? VS_POL : ~VS_POL;
    de_d          = (h_cnt_d >= H_VIS_BEG) && (h_cnt_d < H_VIS_END) &&
                    (v_cnt_d >= V_VIS_BEG) && (v_cnt_d < V_VIS_END);
    line_start_d  = pix_en_q && h_wrap;
    frame_start_d = pix_en_q && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= HS_POL;
      vsync_q       <= VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (small mode /4, tiny mode /1 with
// inverted sync polarity, default 640x480 mode) checked every clk against a
// reference that derives raster position from the number of clks since reset.

module tb_vga_sync_gen;

  // Instance A: small mode, divide by 4.
  localparam int A_D = 4, A_HV = 10, A_HF = 2, A_HS = 3, A_HB = 4;
  localparam int A_VV = 6, A_VF = 1, A_VS = 2, A_VB = 3;
  localparam bit A_HP = 1'b0, A_VP = 1'b0;
  // Instance B: tiny mode, divide by 1, inverted polarities.
  localparam int B_D = 1, B_HV = 4, B_HF = 1, B_HS = 1, B_HB = 2;
  localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam bit B_HP = 1'b1, B_VP = 1'b1;
  // Instance C: default 640x480 timing.
  localparam int C_D = 4, C_HV = 640, C_HF = 16, C_HS = 96, C_HB = 48;
  localparam int C_VV = 480, C_VF = 10, C_VS = 2, C_VB = 33;
  localparam bit C_HP = 1'b0, C_VP = 1'b0;

  localparam int N_CYC = 16000;

  typedef struct packed {
    logic        pix_en;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        pa, pb, pc, hsa, hsb, hsc, vsa, vsb, vsc, dea, deb, dec_o;
  logic        lsa, lsb, lsc, fsa, fsb, fsc;
  logic [10:0] ha, hb, hc, va, vb, vc;
  logic [10:0] hbp_a, hvis_a, vbp_a, vvis_a;
  logic [10:0] hbp_b, hvis_b, vbp_b, vvis_b;
  logic [10:0] hbp_c, hvis_c, vbp_c, vvis_c;

  vga_sync_gen #(.CLK_DIV(A_D), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
                 .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
                 .HS_POL(A_HP), .VS_POL(A_VP)) dut_a (
    .clk(clk), .rst(rst), .pix_en(pa), .h_cnt(ha), .v_cnt(va), .hsync(hsa), .vsync(vsa),
    .de(dea), .line_start(lsa), .frame_start(fsa), .h_back_porch(hbp_a), .h_visible(hvis_a),
    .v_back_porch(vbp_a), .v_visible(vvis_a));

  vga_sync_gen #(.CLK_DIV(B_D), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
                 .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
                 .HS_POL(B_HP), .VS_POL(B_VP)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pb), .h_cnt(hb), .v_cnt(vb), .hsync(hsb), .vsync(vsb),
    .de(deb), .line_start(lsb), .frame_start(fsb), .h_back_porch(hbp_b), .h_visible(hvis_b),
    .v_back_porch(vbp_b), .v_visible(vvis_b));

  vga_sync_gen dut_c (
    .clk(clk), .rst(rst), .pix_en(pc), .h_cnt(hc), .v_cnt(vc), .hsync(hsc), .vsync(vsc),
    .de(dec_o), .line_start(lsc), .frame_start(fsc), .h_back_porch(hbp_c), .h_visible(hvis_c),
    .v_back_porch(vbp_c), .v_visible(vvis_c));

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {pa, ha, va, hsa, vsa, dea, lsa, fsa};
  assign obs_b = {pb, hb, vb, hsb, vsb, deb, lsb, fsb};
  assign obs_c = {pc, hc, vc, hsc, vsc, dec_o, lsc, fsc};

  // Reference: t = rising edges since reset release. pix_en is high after
  // edges D, 2D, ...; the raster advances on the edge after each strobe, so
  // after edge t the pixel index is floor((t-1)/D) modulo the frame size.
  function automatic obs_t model(input int t, input int d,
                                 input int hs, input int hbk, input int hv, input int hf,
                                 input int vs, input int vbk, input int vv, input int vf,
                                 input bit hp, input bit vp);
    obs_t o;
    int ht, vt, adv, n, h, v;
    bit adv_now;
    ht      = hs + hbk + hv + hf;
    vt      = vs + vbk + vv + vf;
    adv     = (t >= 1) ? (t - 1) / d : 0;
    adv_now = (t >= 1) && (((t - 1) % d) == 0) && (((t - 1) / d) >= 1);
    n       = adv % (ht * vt);
    h       = n % ht;
    v       = n / ht;
    o.pix_en = (t >= 1) && ((t % d) == 0);
    o.h      = 11'(h);
    o.v      = 11'(v);
    o.hs     = (h < hs) ? hp : ~hp;
    o.vs     = (v < vs) ? vp : ~vp;
    o.de     = (h >= hs + hbk) && (h < hs + hbk + hv) && (v >= vs + vbk) && (v < vs + vbk + vv);
    o.ls     = adv_now && (h == 0);
    o.fs     = adv_now && (n == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs(input bit hp, input bit vp);
    obs_t o;
    o        = '0;
    o.hs     = hp;
    o.vs     = vp;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".pix_en"},      32'(act.pix_en), 32'(exp.pix_en));
    chk({tag, ".h_cnt"},       32'(act.h),      32'(exp.h));
    chk({tag, ".v_cnt"},       32'(act.v),      32'(exp.v));
    chk({tag, ".hsync"},       32'(act.hs),     32'(exp.hs));
    chk({tag, ".vsync"},       32'(act.vs),     32'(exp.vs));
    chk({tag, ".de"},          32'(act.de),     32'(exp.de));
    chk({tag, ".line_start"},  32'(act.ls),     32'(exp.ls));
    chk({tag, ".frame_start"}, 32'(act.fs),     32'(exp.fs));
  endtask

  exp_t sb[$];

  // Monitor: pops one expectation per clk and compares; also measures frame
  // period and visible-pixel clks between successive frame_start pulses.
  int  fr_len[2];
  int  fr_de[2];
  bit  fr_have[2];
  int  frames[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      fr_len[i] = 0; fr_de[i] = 0; fr_have[i] = 1'b0; frames[i] = 0;
    end
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_obs("A", obs_a, e.a);
        check_obs("B", obs_b, e.b);
        check_obs("C", obs_c, e.c);
      end
      for (int i = 0; i < 2; i++) begin
        logic fs_i, de_i;
        int   per, dpx;
        fs_i = (i == 0) ? fsa : fsb;
        de_i = (i == 0) ? dea : deb;
        per  = (i == 0) ? (A_HS + A_HB + A_HV + A_HF) * (A_VS + A_VB + A_VV + A_VF) * A_D
                        : (B_HS + B_HB + B_HV + B_HF) * (B_VS + B_VB + B_VV + B_VF) * B_D;
        dpx  = (i == 0) ? A_HV * A_VV * A_D : B_HV * B_VV * B_D;
        if (rst) begin
          fr_have[i] = 1'b0;
        end else begin
          fr_len[i]++;
          if (de_i) fr_de[i]++;
          if (fs_i) begin
            if (fr_have[i]) begin
              chk((i == 0) ? "A.frame_period" : "B.frame_period", 32'(fr_len[i]), 32'(per));
              chk((i == 0) ? "A.de_clks_per_frame" : "B.de_clks_per_frame", 32'(fr_de[i]), 32'(dpx));
              frames[i]++;
            end
            fr_have[i] = 1'b1;
            fr_len[i]  = 0;
            fr_de[i]   = 0;
          end
        end
      end
    end
  end

  // Driver: owns reset (asserted asynchronously between edges, at random
  // points) and pushes the expected state after each edge.
  initial begin
    int   t;
    int   hold;
    exp_t e;
    t    = 0;
    hold = 3;
    rst  = 1'b1;

    // Window constants do not depend on reset or time.
    chk("A.h_back_porch", 32'(hbp_a), 32'(A_HS + A_HB));
    chk("A.v_back_porch", 32'(vbp_a), 32'(A_VS + A_VB));
    chk("B.h_visible",    32'(hvis_b), 32'(B_HV));
    chk("B.v_visible",    32'(vvis_b), 32'(B_VV));
    chk("C.h_back_porch", 32'(hbp_c), 32'd144);
    chk("C.h_visible",    32'(hvis_c), 32'd640);
    chk("C.v_back_porch", 32'(vbp_c), 32'd35);
    chk("C.v_visible",    32'(vvis_c), 32'd480);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      if (rst) t = 0;
      else     t++;
      #($urandom_range(1, 3));
      if (hold > 0) begin
        rst = 1'b1;
        hold--;
      end else if (cyc == 4500 ||
                   (cyc > 5000 && cyc < N_CYC - 5000 && $urandom_range(0, 999) == 0)) begin
        rst  = 1'b1;
        hold = $urandom_range(0, 4);
      end else begin
        rst = 1'b0;
      end
      if (rst) begin
        e.a = reset_obs(A_HP, A_VP);
        e.b = reset_obs(B_HP, B_VP);
        e.c = reset_obs(C_HP, C_VP);
      end else begin
        e.a = model(t, A_D, A_HS, A_HB, A_HV, A_HF, A_VS, A_VB, A_VV, A_VF, A_HP, A_VP);
        e.b = model(t, B_D, B_HS, B_HB, B_HV, B_HF, B_VS, B_VB, B_VV, B_VF, B_HP, B_VP);
        e.c = model(t, C_D, C_HS, C_HB, C_HV, C_HF, C_VS, C_VB, C_VV, C_VF, C_HP, C_VP);
      end
      sb.push_back(e);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("A.frames_measured_ge3", 32'(frames[0] >= 3), 32'd1);
    chk("B.frames_measured_ge3", 32'(frames[1] >= 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
